// File: rtl/sdram_port_arb.sv
// Arbiter between a byte loader (one-entry write buffer) and a tape reader for a single SDRAM port.
// Each command waits at most TIMEOUT cycles for mem_ready before being aborted.
module sdram_port_arb #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        ld_wr_i,
    input  logic [24:0] ld_addr_i,
    input  logic [7:0]  ld_data_i,
    output logic        ld_ovf_o,
    input  logic        rd_req_i,
    input  logic [24:0] rd_addr_i,
    output logic [7:0]  rd_data_o,
    output logic        rd_ack_o,
    output logic [24:0] mem_addr_o,
    output logic [7:0]  mem_din_o,
    output logic        mem_we_o,
    output logic        mem_rd_o,
    input  logic [7:0]  mem_dout_i,
    input  logic        mem_ready_i,
    output logic        mem_timeout_o,
    output logic        busy_o
);

    localparam logic [7:0] TimeoutM1 = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;

    state_e      state_q, state_d;
    logic        buf_full_q, buf_full_d;
    logic [24:0] buf_addr_q, buf_addr_d;
    logic [7:0]  buf_data_q, buf_data_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        armed_q;
    logic [24:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_din_q, mem_din_d;
    logic        mem_we_q, mem_we_d;
    logic        mem_rd_q, mem_rd_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        rd_ack_q, rd_ack_d;
    logic        ld_ovf_q, ld_ovf_d;
    logic        mem_timeout_q, mem_timeout_d;
    logic        busy_q, busy_d;
    logic        deq;
    logic        want_wr, want_rd;

    always_comb begin
        state_d       = state_q;
        buf_full_d    = buf_full_q;
        buf_addr_d    = buf_addr_q;
        buf_data_d    = buf_data_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        mem_addr_d    = mem_addr_q;
        mem_din_d     = mem_din_q;
        mem_we_d      = 1'b0;
        mem_rd_d      = 1'b0;
        rd_data_d     = rd_data_q;
        rd_ack_d      = 1'b0;
        ld_ovf_d      = ld_ovf_q;
        mem_timeout_d = mem_timeout_q;
        deq           = 1'b0;
        // A request still high during its own ack cycle is the one just served.
        want_wr       = buf_full_q;
        want_rd       = rd_req_i && !rd_ack_q;

        unique case (state_q)
            StIdle: begin
                if (armed_q && (want_wr || want_rd)) begin
                    cnt_d = 8'd0;
                    if (want_wr && (!want_rd || !last_grant_q)) begin
                        state_d      = StWrite;
                        mem_addr_d   = buf_addr_q;
                        mem_din_d    = buf_data_q;
                        mem_we_d     = 1'b1;
                        deq          = 1'b1;
                        last_grant_d = 1'b1;
                    end else begin
                        state_d      = StRead;
                        mem_addr_d   = rd_addr_i;
                        mem_rd_d     = 1'b1;
                        last_grant_d = 1'b0;
                    end
                end
            end
            StWrite, StRead: begin
                cnt_d = cnt_q + 8'd1;
                if (mem_ready_i) begin
                    state_d = StIdle;
                    if (state_q == StRead) begin
                        rd_data_d = mem_dout_i;
                        rd_ack_d  = 1'b1;
                    end
                end else if (cnt_q == TimeoutM1) begin
                    state_d       = StIdle;
                    mem_timeout_d = 1'b1;
                    if (state_q == StRead) begin
                        rd_data_d = 8'hFF;
                        rd_ack_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A dequeue in the same cycle frees the slot for the incoming byte.
        if (ld_wr_i) begin
            if (!buf_full_q || deq) begin
                buf_full_d = 1'b1;
                buf_addr_d = ld_addr_i;
                buf_data_d = ld_data_i;
            end else begin
                ld_ovf_d = 1'b1;
            end
        end else if (deq) begin
            buf_full_d = 1'b0;
        end

        busy_d = (state_d != StIdle) || buf_full_d;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= StIdle;
            buf_full_q    <= 1'b0;
            buf_addr_q    <= '0;
            buf_data_q    <= '0;
            last_grant_q  <= 1'b0;
            cnt_q         <= '0;
            armed_q       <= 1'b0;
            mem_addr_q    <= '0;
            mem_din_q     <= '0;
            mem_we_q      <= 1'b0;
            mem_rd_q      <= 1'b0;
            rd_data_q     <= '0;
            rd_ack_q      <= 1'b0;
            ld_ovf_q      <= 1'b0;
            mem_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            buf_full_q    <= buf_full_d;
            buf_addr_q    <= buf_addr_d;
            buf_data_q    <= buf_data_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            // Holds off the first grant until the second edge after release.
            armed_q       <= 1'b1;
            mem_addr_q    <= mem_addr_d;
            mem_din_q     <= mem_din_d;
            mem_we_q      <= mem_we_d;
            mem_rd_q      <= mem_rd_d;
            rd_data_q     <= rd_data_d;
            rd_ack_q      <= rd_ack_d;
            ld_ovf_q      <= ld_ovf_d;
            mem_timeout_q <= mem_timeout_d;
            busy_q        <= busy_d;
        end
    end

    assign ld_ovf_o      = ld_ovf_q;
    assign rd_data_o     = rd_data_q;
    assign rd_ack_o      = rd_ack_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_din_o     = mem_din_q;
    assign mem_we_o      = mem_we_q;
    assign mem_rd_o      = mem_rd_q;
    assign mem_timeout_o = mem_timeout_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_sdram_port_arb.sv
// Randomised bench for sdram_port_arb: a transaction-level model predicts every output per cycle,
// and the bench plays the SDRAM, choosing each command's latency when the model grants it.
module tb_sdram_port_arb;

    localparam int Timeout   = 15;
    localparam int NumCycles = 4000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ld_wr = 1'b0;
    logic [24:0] ld_addr = '0;
    logic [7:0]  ld_data = '0;
    logic        rd_req = 1'b0;
    logic [24:0] rd_addr = '0;
    logic [7:0]  mem_dout = '0;
    logic        mem_ready = 1'b0;
    logic        ld_ovf, rd_ack, mem_we, mem_rd, mem_timeout, busy;
    logic [7:0]  rd_data, mem_din;
    logic [24:0] mem_addr;

    sdram_port_arb #(.TIMEOUT(Timeout)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .ld_wr_i      (ld_wr),
        .ld_addr_i    (ld_addr),
        .ld_data_i    (ld_data),
        .ld_ovf_o     (ld_ovf),
        .rd_req_i     (rd_req),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_data),
        .rd_ack_o     (rd_ack),
        .mem_addr_o   (mem_addr),
        .mem_din_o    (mem_din),
        .mem_we_o     (mem_we),
        .mem_rd_o     (mem_rd),
        .mem_dout_i   (mem_dout),
        .mem_ready_i  (mem_ready),
        .mem_timeout_o(mem_timeout),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Model state: kind 0 = no command, 1 = write, 2 = read; k = cycle index inside the command.
    bit          m_armed, m_last_w, m_full;
    int          m_kind, m_k, m_dur, m_lat;
    logic [24:0] m_baddr;
    logic [7:0]  m_bdata;
    logic        e_ld_ovf, e_rd_ack, e_mem_we, e_mem_rd, e_mem_timeout, e_busy;
    logic [7:0]  e_rd_data, e_mem_din;
    logic [24:0] e_mem_addr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_eq("mem_we", 32'(mem_we), 32'(e_mem_we));
        check_eq("mem_rd", 32'(mem_rd), 32'(e_mem_rd));
        check_eq("mem_addr", 32'(mem_addr), 32'(e_mem_addr));
        check_eq("mem_din", 32'(mem_din), 32'(e_mem_din));
        check_eq("rd_ack", 32'(rd_ack), 32'(e_rd_ack));
        check_eq("rd_data", 32'(rd_data), 32'(e_rd_data));
        check_eq("ld_ovf", 32'(ld_ovf), 32'(e_ld_ovf));
        check_eq("mem_timeout", 32'(mem_timeout), 32'(e_mem_timeout));
        check_eq("busy", 32'(busy), 32'(e_busy));
    endtask

    task automatic model_reset();
        m_armed = 0; m_last_w = 0; m_full = 0; m_kind = 0; m_k = 0; m_dur = 0; m_lat = 0;
        m_baddr = '0; m_bdata = '0;
        e_ld_ovf = 0; e_rd_ack = 0; e_mem_we = 0; e_mem_rd = 0; e_mem_timeout = 0; e_busy = 0;
        e_rd_data = '0; e_mem_din = '0; e_mem_addr = '0;
    endtask

    task automatic drive_inputs();
        ld_wr   = ($urandom_range(0, 7) == 0);
        ld_addr = 25'($urandom);
        ld_data = 8'($urandom);
        if (!rd_req) begin
            if ($urandom_range(0, 3) == 0) begin
                rd_req  = 1'b1;
                rd_addr = 25'($urandom);
            end
        end else if (e_rd_ack) begin
            rd_req  = ($urandom_range(0, 1) == 0);
            rd_addr = 25'($urandom);
        end
        mem_dout  = 8'($urandom);
        // Stray mem_ready pulses while idle must be ignored.
        mem_ready = (m_kind != 0) ? (m_k == m_lat + 1) : ($urandom_range(0, 3) == 0);
    endtask

    task automatic model_step();
        logic n_we, n_rd, n_ack, deq, pick_w, want_w, want_r;
        n_we = 0; n_rd = 0; n_ack = 0; deq = 0;
        if (m_kind != 0) begin
            if (m_k == m_dur) begin
                if (m_kind == 2) begin
                    n_ack     = 1;
                    e_rd_data = (m_lat < Timeout) ? mem_dout : 8'hFF;
                end
                if (m_lat >= Timeout) e_mem_timeout = 1;
                m_kind = 0;
            end else begin
                m_k++;
            end
        end else if (m_armed) begin
            want_w = m_full;
            want_r = rd_req && !e_rd_ack;
            if (want_w || want_r) begin
                pick_w = want_w && !(want_r && m_last_w);
                m_lat  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, Timeout + 2))
                                                     : int'($urandom_range(0, 3));
                m_dur  = (m_lat < Timeout) ? m_lat + 1 : Timeout;
                m_k    = 1;
                m_last_w = pick_w;
                if (pick_w) begin
                    m_kind = 1; e_mem_addr = m_baddr; e_mem_din = m_bdata; n_we = 1; deq = 1;
                end else begin
                    m_kind = 2; e_mem_addr = rd_addr; n_rd = 1;
                end
            end
        end
        if (ld_wr) begin
            if (!m_full || deq) begin
                m_full = 1; m_baddr = ld_addr; m_bdata = ld_data;
            end else begin
                e_ld_ovf = 1;
            end
        end else if (deq) begin
            m_full = 0;
        end
        m_armed  = 1;
        e_mem_we = n_we;
        e_mem_rd = n_rd;
        e_rd_ack = n_ack;
        e_busy   = (m_kind != 0) || m_full;
    endtask

    // Asynchronous reset mid-cycle: outputs must clear before the next edge.
    task automatic do_reset();
        #2;
        reset     = 1'b1;
        ld_wr     = 1'b0;
        mem_ready = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int next_rst;
        model_reset();
        #1;
        reset = 1'b1;
        #1;
        check_outputs();
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        next_rst = 400;
        for (int cyc = 0; cyc < NumCycles; cyc++) begin
            check_outputs();
            if (cyc >= next_rst && m_kind != 0) begin
                do_reset();
                next_rst = cyc + 400 + int'($urandom_range(0, 200));
            end
            drive_inputs();
            model_step();
            @(negedge clk);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/sdram_port_arb.md
SDRAM_PORT_ARB -- requirements
Module: sdram_port_arb

Interface
REQ-001 Parameter TIMEOUT, default 15, max cycles a command waits for mem_ready before abort (legal 2..255).
REQ-002 clk  in  1  system clock (57.272 MHz clk_sys); all logic on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 ld_wr  in  1  loader write strobe, one-cycle pulse (ioctl_wr qualified by tape index).
REQ-005 ld_addr  in  25  loader byte address, valid with ld_wr.
REQ-006 ld_data  in  8  loader byte, valid with ld_wr.
REQ-007 ld_ovf  out  1  sticky: a loader write was dropped.
REQ-008 rd_req  in  1  tape reader request, level, held until rd_ack.
REQ-009 rd_addr  in  25  reader address, stable while rd_req=1.
REQ-010 rd_data  out  8  read result, valid in rd_ack cycle, held until next ack.
REQ-011 rd_ack  out  1  one-cycle read completion pulse.
REQ-012 mem_addr  out  25  SDRAM address.
REQ-013 mem_din  out  8  SDRAM write data.
REQ-014 mem_we  out  1  SDRAM write strobe.
REQ-015 mem_rd  out  1  SDRAM read strobe.
REQ-016 mem_dout  in  8  SDRAM read data, valid with mem_ready.
REQ-017 mem_ready  in  1  SDRAM completion pulse.
REQ-018 mem_timeout  out  1  sticky: a command timed out.
REQ-019 busy  out  1  high when state != IDLE or write buffer full.

Function
REQ-020 States IDLE, WRITE, READ; all outputs registered.
REQ-021 One-entry write buffer (addr, data, full flag) captures ld_wr.
REQ-022 ld_wr with buffer empty -> capture; full flag set next cycle.
REQ-023 ld_wr with buffer full and same-cycle dequeue -> capture new entry, full stays 1.
REQ-024 ld_wr with buffer full, no dequeue -> entry dropped, ld_ovf=1 until reset.
REQ-025 IDLE grant: only buffer full -> WRITE; only rd_req (and rd_ack=0) -> READ; both -> opposite of last_grant.
REQ-026 Grant at edge N: state, mem_addr, mem_din (write) loaded; mem_we or mem_rd high for exactly cycle N+1 only; buffer dequeued at edge N.
REQ-027 mem_addr/mem_din held constant for entire WRITE/READ state.
REQ-028 mem_ready sampled only in WRITE/READ; ignored in IDLE and in strobe cycle's predecessor.
REQ-029 WRITE + mem_ready -> IDLE next edge.
REQ-030 READ + mem_ready -> IDLE next edge; same edge rd_data<=mem_dout, rd_ack=1 for one cycle.
REQ-031 rd_req ignored while rd_ack=1 (no double service); min one IDLE cycle between transactions.
REQ-032 8-bit wait counter cleared on grant, increments each WRITE/READ cycle; reaching TIMEOUT without mem_ready -> IDLE, mem_timeout=1.
REQ-033 Read timeout -> rd_data=8'hFF, rd_ack pulsed; write timeout -> write discarded.
REQ-034 mem_ready and timeout in same cycle -> mem_ready wins, no timeout flag.
REQ-035 last_grant updated on every grant (1=write, 0=read).

Reset
REQ-036 reset=1 -> state IDLE, buffer empty, last_grant=0, counter 0, all outputs 0 (rd_data 8'h00), immediately (asynchronous).
REQ-037 Reset mid-transaction aborts it: no rd_ack, buffered/in-flight write lost, no flags set.
REQ-038 First grant after reset release no earlier than second rising edge.

Verification
REQ-039 ld_wr addr 0x000010 data 0xA5, mem_ready 3 cycles after mem_we -> mem_we 1 cycle, mem_addr 0x000010, mem_din 0xA5, back IDLE, ld_ovf=0.
REQ-040 rd_req addr 0x000200, mem_ready with mem_dout 0x3C -> rd_ack 1 cycle later, rd_data 0x3C, single mem_rd pulse.
REQ-041 buffer full + rd_req pending, last_grant=0 -> WRITE then READ; repeat with last_grant=1 -> READ first.
REQ-042 three ld_wr on consecutive cycles while READ stalled -> first buffered, others dropped, ld_ovf=1, only first written.
REQ-043 rd_req, mem_ready never asserted, TIMEOUT=15 -> rd_ack after 15 READ cycles, rd_data 0xFF, mem_timeout=1.
REQ-044 reset asserted during READ -> outputs 0 same cycle, no rd_ack; after release rd_req still high -> new READ issued.
